// File: rtl/dds_accum_multi.sv
// Multi-channel DDS phase accumulator with slew-limited increments and one-shot phase adjust.
// Latency: cur_inc reaches phase one cycle after it updates; an accepted adjust lands on the following edge.
// Backpressure: phase_adj_ready drops for the single APPLY cycle after each accept.
module dds_accum_multi #(
  parameter int                   N_CH           = 2,
  parameter int                   ACC_WIDTH      = 32,
  parameter int                   SLEW_DIV_WIDTH = 16,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INC    = 32'h33333333,
  parameter int                   CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       clk_ref,
  input  logic                       reset_in,
  input  logic [N_CH*ACC_WIDTH-1:0]  target_inc,
  input  logic [ACC_WIDTH-1:0]       slew_step,
  input  logic [SLEW_DIV_WIDTH-1:0]  slew_div,
  input  logic                       phase_adj_valid,
  output logic                       phase_adj_ready,
  input  logic [CH_W-1:0]            phase_adj_ch,
  input  logic [ACC_WIDTH-1:0]       phase_adj_value,
  output logic [N_CH-1:0]            dds_out,
  output logic [N_CH*ACC_WIDTH-1:0]  phase,
  output logic [N_CH*ACC_WIDTH-1:0]  cur_inc,
  output logic [N_CH-1:0]            slewing
);

  typedef logic [ACC_WIDTH-1:0] acc_t;
  typedef enum logic {ST_IDLE, ST_APPLY} adj_state_e;

  acc_t                      phase_q   [N_CH];
  acc_t                      phase_d   [N_CH];
  acc_t                      cur_inc_q [N_CH];
  acc_t                      cur_inc_d [N_CH];
  logic [N_CH-1:0]           slewing_q, slewing_d;
  logic [N_CH-1:0]           adj_hit;
  logic [SLEW_DIV_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic                      tick;
  adj_state_e                state_q, state_d;
  logic                      ready_q, ready_d;
  logic [CH_W-1:0]           adj_ch_q, adj_ch_d;
  acc_t                      adj_val_q, adj_val_d;

  // Slew tick divider; compares against the live slew_div each cycle.
  always_comb begin
    tick       = (tick_cnt_q >= slew_div);
    tick_cnt_d = tick ? '0 : tick_cnt_q + SLEW_DIV_WIDTH'(1);
  end

  // Per-channel increment slewing toward target, clamped so it never overshoots.
  // slewing compares the increment in use this cycle, so it stays up through the
  // edge that lands on target and drops one edge later.
  always_comb begin : slew_calc
    acc_t tgt;
    acc_t diff;
    for (int i = 0; i < N_CH; i++) begin
      tgt          = target_inc[i*ACC_WIDTH +: ACC_WIDTH];
      diff         = (tgt >= cur_inc_q[i]) ? (tgt - cur_inc_q[i]) : (cur_inc_q[i] - tgt);
      cur_inc_d[i] = cur_inc_q[i];
      if (tick) begin
        if ((slew_step == '0) || (diff <= slew_step)) begin
          cur_inc_d[i] = tgt;
        end else if (tgt > cur_inc_q[i]) begin
          cur_inc_d[i] = cur_inc_q[i] + slew_step;
        end else begin
          cur_inc_d[i] = cur_inc_q[i] - slew_step;
        end
      end
      slewing_d[i] = (cur_inc_q[i] != tgt);
    end
  end

  // Accumulator next value: old increment plus any one-shot adjust, wrapping.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      adj_hit[i] = (state_q == ST_APPLY) && (adj_ch_q == CH_W'(i));
      phase_d[i] = phase_q[i] + cur_inc_q[i] + (adj_hit[i] ? adj_val_q : '0);
    end
  end

  // Phase-adjust handshake next-state; out-of-range channels simply hit nothing.
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    adj_ch_d  = adj_ch_q;
    adj_val_d = adj_val_q;
    case (state_q)
      ST_IDLE: begin
        if (phase_adj_valid && ready_q) begin
          adj_ch_d  = phase_adj_ch;
          adj_val_d = phase_adj_value;
          state_d   = ST_APPLY;
          ready_d   = 1'b0;
        end
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Phase-adjust FSM state and registered ready.
  always_ff @(posedge clk_ref or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      adj_ch_q  <= '0;
      adj_val_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      adj_ch_q  <= adj_ch_d;
      adj_val_q <= adj_val_d;
    end
  end

  // Accumulators, increments, slewing flags and tick counter.
  always_ff @(posedge clk_ref or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < N_CH; i++) begin
        phase_q[i]   <= '0;
        cur_inc_q[i] <= DEFAULT_INC;
      end
      slewing_q  <= '0;
      tick_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        phase_q[i]   <= phase_d[i];
        cur_inc_q[i] <= cur_inc_d[i];
      end
      slewing_q  <= slewing_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Pack per-channel registers onto the flat output buses.
  always_comb begin
    phase   = '0;
    cur_inc = '0;
    dds_out = '0;
    for (int i = 0; i < N_CH; i++) begin
      phase[i*ACC_WIDTH +: ACC_WIDTH]   = phase_q[i];
      cur_inc[i*ACC_WIDTH +: ACC_WIDTH] = cur_inc_q[i];
      dds_out[i]                        = phase_q[i][ACC_WIDTH-1];
    end
  end

  assign slewing         = slewing_q;
  assign phase_adj_ready = ready_q;

endmodule

// File: tb/tb_dds_accum_multi.sv
// Directed bench for dds_accum_multi: reset, wrap, jump, slew up/down, phase adjust, async reset.
// A second 3-channel instance exercises an out-of-range adjust channel.
module tb_dds_accum_multi;

  localparam logic [31:0] DEF = 32'h33333333;

  logic        clk_ref = 1'b0;
  logic        reset_in;
  logic [63:0] target_inc;
  logic [31:0] slew_step;
  logic [15:0] slew_div;
  logic        adj_valid;
  logic        adj_ready;
  logic        adj_ch;
  logic [31:0] adj_value;
  logic [1:0]  dds_out;
  logic [63:0] phase;
  logic [63:0] cur_inc;
  logic [1:0]  slewing;

  logic [95:0] target3;
  logic        valid3;
  logic        ready3;
  logic [1:0]  ch3;
  logic [31:0] value3;
  logic [2:0]  dds3;
  logic [95:0] phase3;
  logic [95:0] cur3;
  logic [2:0]  slewing3;

  logic [31:0] ph0, ph1, cur0, cur1;
  assign ph0  = phase[31:0];
  assign ph1  = phase[63:32];
  assign cur0 = cur_inc[31:0];
  assign cur1 = cur_inc[63:32];

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] t1_ph [0:5];
  logic [5:0]  t1_dds;

  always #5 clk_ref = ~clk_ref;

  dds_accum_multi dut (
    .clk_ref        (clk_ref),
    .reset_in       (reset_in),
    .target_inc     (target_inc),
    .slew_step      (slew_step),
    .slew_div       (slew_div),
    .phase_adj_valid(adj_valid),
    .phase_adj_ready(adj_ready),
    .phase_adj_ch   (adj_ch),
    .phase_adj_value(adj_value),
    .dds_out        (dds_out),
    .phase          (phase),
    .cur_inc        (cur_inc),
    .slewing        (slewing)
  );

  dds_accum_multi #(.N_CH(3)) dut3 (
    .clk_ref        (clk_ref),
    .reset_in       (reset_in),
    .target_inc     (target3),
    .slew_step      (32'h0),
    .slew_div       (16'h0),
    .phase_adj_valid(valid3),
    .phase_adj_ready(ready3),
    .phase_adj_ch   (ch3),
    .phase_adj_value(value3),
    .dds_out        (dds3),
    .phase          (phase3),
    .cur_inc        (cur3),
    .slewing        (slewing3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_ref);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    t1_ph[0] = 32'h33333333; t1_ph[1] = 32'h66666666; t1_ph[2] = 32'h99999999;
    t1_ph[3] = 32'hCCCCCCCC; t1_ph[4] = 32'hFFFFFFFF; t1_ph[5] = 32'h33333332;
    t1_dds   = 6'b011100;

    reset_in   = 1'b1;
    target_inc = {DEF, DEF};
    slew_step  = 32'h0;
    slew_div   = 16'h0;
    adj_valid  = 1'b0;
    adj_ch     = 1'b0;
    adj_value  = 32'h0;
    target3    = {DEF, DEF, DEF};
    valid3     = 1'b0;
    ch3        = 2'd0;
    value3     = 32'h0;
    #1;

    // Reset state
    chk("rst_phase",   phase,     64'h0);
    chk("rst_dds",     dds_out,   64'h0);
    chk("rst_cur_inc", cur_inc,   {DEF, DEF});
    chk("rst_slewing", slewing,   64'h0);
    chk("rst_ready",   adj_ready, 64'h1);
    step();
    step();
    chk("rst_hold_phase", phase, 64'h0);
    reset_in = 1'b0;

    // 1: free run at default increment, wrap on sixth cycle
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t1_ph0",     ph0,     t1_ph[k]);
      chk("t1_ph1",     ph1,     t1_ph[k]);
      chk("t1_dds",     dds_out, {62'h0, t1_dds[k], t1_dds[k]});
      chk("t1_slewing", slewing, 64'h0);
    end

    // 2: direct jump with slew_step=0, tick every cycle
    target_inc[31:0] = 32'h40000000;
    step();
    chk("t2_cur0",  cur0,       32'h40000000);
    chk("t2_slew0", slewing[0], 1'b1);
    chk("t2_ph0a",  ph0,        32'h66666665);
    chk("t2_cur1",  cur1,       DEF);
    chk("t2_slew1", slewing[1], 1'b0);
    step();
    chk("t2_slew0_fall", slewing[0], 1'b0);
    chk("t2_ph0b",       ph0,        32'hA6666665);
    chk("t2_cur0_hold",  cur0,       32'h40000000);

    // 3: slew up by 0x01000000 every 4 cycles
    reset_in   = 1'b1;
    target_inc = {DEF, 32'h35333333};
    slew_step  = 32'h01000000;
    slew_div   = 16'd3;
    #1;
    chk("t3_rst_cur0", cur0, DEF);
    reset_in = 1'b0;
    step();
    chk("t3_e1_slew0", slewing[0], 1'b1);
    chk("t3_e1_cur0",  cur0,       DEF);
    step(); step();
    chk("t3_e3_cur0",  cur0,       DEF);
    step();
    chk("t3_e4_cur0",  cur0,       32'h34333333);
    chk("t3_e4_cur1",  cur1,       DEF);
    chk("t3_e4_slew1", slewing[1], 1'b0);
    step(); step(); step();
    chk("t3_e7_cur0",  cur0,       32'h34333333);
    step();
    chk("t3_e8_cur0",  cur0,       32'h35333333);
    chk("t3_e8_slew0", slewing[0], 1'b1);
    step();
    chk("t3_e9_slew0", slewing[0], 1'b0);
    chk("t3_e9_cur1",  cur1,       DEF);

    // 4: slew down to a non-multiple of the step
    reset_in   = 1'b1;
    target_inc = {DEF, 32'h33000000};
    slew_step  = 32'h00200000;
    #1;
    reset_in = 1'b0;
    step(); step(); step(); step();
    chk("t4_e4_cur0", cur0, 32'h33133333);
    step(); step(); step();
    chk("t4_e7_cur0", cur0, 32'h33133333);
    step();
    chk("t4_e8_cur0", cur0, 32'h33000000);
    step();
    chk("t4_e9_slew0", slewing[0], 1'b0);

    // 5: phase adjust ch1 by half a turn; out-of-range channel on 3-ch instance
    reset_in   = 1'b1;
    target_inc = {DEF, DEF};
    slew_step  = 32'h0;
    slew_div   = 16'd0;
    #1;
    reset_in = 1'b0;
    step();
    chk("t5_ready_idle", adj_ready, 1'b1);
    adj_valid = 1'b1; adj_ch = 1'b1; adj_value = 32'h80000000;
    valid3    = 1'b1; ch3    = 2'd3; value3    = 32'h80000000;
    step();
    chk("t5_ready_low",  adj_ready, 1'b0);
    chk("t5_ready3_low", ready3,    1'b0);
    chk("t5_ph1_pre",    ph1,       32'h66666666);
    adj_valid = 1'b0;
    valid3    = 1'b0;
    step();
    chk("t5_ready_back",  adj_ready, 1'b1);
    chk("t5_ready3_back", ready3,    1'b1);
    chk("t5_ph0",         ph0,       32'h99999999);
    chk("t5_ph1",         ph1,       32'h19999999);
    chk("t5_dds",         dds_out,   64'h1);
    chk("t5_oor_ph0",     phase3[31:0],  32'h99999999);
    chk("t5_oor_ph1",     phase3[63:32], 32'h99999999);
    chk("t5_oor_ph2",     phase3[95:64], 32'h99999999);
    step();
    chk("t5_ph1_next", ph1,     32'h4CCCCCCC);
    chk("t5_dds_next", dds_out, 64'h1);

    // 5b: valid held for 6 cycles accepts exactly 3 adjustments of +1
    reset_in = 1'b1;
    #1;
    reset_in  = 1'b0;
    adj_valid = 1'b1; adj_ch = 1'b1; adj_value = 32'h00000001;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t5b_ready", adj_ready, {63'h0, ~k[0]});
    end
    adj_valid = 1'b0;
    chk("t5b_ph0", ph0, 32'h33333332);
    chk("t5b_ph1", ph1, 32'h33333335);
    step();
    chk("t5b_ph1_after", ph1, 32'h66666668);

    // 6: async reset mid-slew and during APPLY
    reset_in   = 1'b1;
    target_inc = {DEF, 32'h35333333};
    slew_step  = 32'h01000000;
    slew_div   = 16'd3;
    #1;
    reset_in = 1'b0;
    step(); step(); step();
    adj_valid = 1'b1; adj_ch = 1'b0; adj_value = 32'h40000000;
    step();
    chk("t6_pre_cur0",  cur0,      32'h34333333);
    chk("t6_pre_ready", adj_ready, 1'b0);
    adj_valid = 1'b0;
    reset_in  = 1'b1;
    #2;
    chk("t6_rst_phase", phase,     64'h0);
    chk("t6_rst_dds",   dds_out,   64'h0);
    chk("t6_rst_cur",   cur_inc,   {DEF, DEF});
    chk("t6_rst_slew",  slewing,   64'h0);
    chk("t6_rst_ready", adj_ready, 1'b1);
    target_inc = {DEF, DEF};
    reset_in   = 1'b0;
    step();
    chk("t6_ph0",   ph0,       32'h33333333);
    chk("t6_ph1",   ph1,       32'h33333333);
    chk("t6_ready", adj_ready, 1'b1);
    step();
    chk("t6_ph0_next", ph0, 32'h66666666);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
